// File: rtl/pkmc_cmdseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkmc_cmdseq_pkg
//  Description : Shared SDRAM command encodings for the pkmc controller,
//                plus the latched-access record and the RD/WR address
//                helper used by the command sequencer.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================

// SDRAM command words {cs_n, ras_n, cas_n, we_n}. These are shared with the
// downstream command-decoder comparators, so they remain plain defines.
`ifndef PKMC_SDRAM_DEFINES
`define PKMC_SDRAM_DEFINES
`define PKMC_COMMAND_LEN 4
`define PKMC_CMD_NOP 4'b0111
`define PKMC_CMD_PRE 4'b0010
`define PKMC_CMD_REF 4'b0001
`define PKMC_CMD_LMR 4'b0000
`define PKMC_CMD_ACT 4'b0011
`define PKMC_CMD_RD  4'b0101
`define PKMC_CMD_WR  4'b0100
`endif

package pkmc_cmdseq_pkg;

    localparam int COMMAND_LEN = `PKMC_COMMAND_LEN;

    typedef logic [COMMAND_LEN-1:0] cmd_t;

    localparam cmd_t c_CMD_NOP = `PKMC_CMD_NOP;
    localparam cmd_t c_CMD_PRE = `PKMC_CMD_PRE;
    localparam cmd_t c_CMD_REF = `PKMC_CMD_REF;
    localparam cmd_t c_CMD_LMR = `PKMC_CMD_LMR;
    localparam cmd_t c_CMD_ACT = `PKMC_CMD_ACT;
    localparam cmd_t c_CMD_RD  = `PKMC_CMD_RD;
    localparam cmd_t c_CMD_WR  = `PKMC_CMD_WR;

    // Access fields captured in the ACT cycle; the row is only needed in
    // that cycle, so it is not kept.
    typedef struct packed {
        logic       we;
        logic [1:0] bank;
        logic [7:0] col;
    } acc_t;

    // Column address for RD/WR with A10 set so the bank auto-precharges.
    function automatic logic [11:0] rw_addr(input logic [7:0] col);
        return {1'b0, 1'b1, 2'b00, col};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pkmc_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pkmc_refresh_timer
//  Description : Auto-refresh interval counter with a saturating pending
//                flag. Counts only while enabled; every REF_INTERVAL cycles
//                it raises ref_pending, which stays set until acknowledged.
//  Ports       : clk_i          - system clock
//                rst_i          - synchronous active-high reset
//                enable_i       - counting enable (init sequence complete)
//                ack_refresh_i  - a refresh is being issued; clear pending
//                ref_pending_o  - a refresh is owed
//  Revision    : 1.0 - initial release
// ============================================================================
module pkmc_refresh_timer #(
    parameter int REF_INTERVAL = 780
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic ack_refresh_i,
    output logic ref_pending_o
);

    localparam logic [15:0] c_RELOAD = 16'(REF_INTERVAL - 1);

    logic [15:0] r_cnt_q;
    logic [15:0] w_cnt_d;
    logic        r_pending_q;
    logic        w_pending_d;

    always_comb begin
        w_cnt_d     = r_cnt_q;
        w_pending_d = r_pending_q;
        if (ack_refresh_i) begin
            w_pending_d = 1'b0;
        end
        if (!enable_i) begin
            w_cnt_d = c_RELOAD;
        end else if (r_cnt_q == 16'd0) begin
            // A fresh expiry beats a same-cycle acknowledge; a second
            // expiry while still pending simply leaves the flag set.
            w_cnt_d     = c_RELOAD;
            w_pending_d = 1'b1;
        end else begin
            w_cnt_d = r_cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt_q     <= c_RELOAD;
            r_pending_q <= 1'b0;
        end else begin
            r_cnt_q     <= w_cnt_d;
            r_pending_q <= w_pending_d;
        end
    end

    assign ref_pending_o = r_pending_q;

endmodule

`default_nettype wire

// File: rtl/pkmc_cmdseq.sv
`default_nettype none
// ============================================================================
//  Module      : pkmc_cmdseq
//  Description : SDRAM command sequencer. Runs the power-up init sequence,
//                periodic auto-refresh and single-word auto-precharge
//                read/write accesses. All outputs are registered.
//  Ports       : clk_i, rst_i        - clock, synchronous active-high reset
//                req_i, we_i         - access request (held until ack_o), dir
//                bank_i/row_i/col_i  - access address
//                ack_o               - one-cycle access acknowledge
//                rd_valid_o          - capture read data this cycle
//                command_o           - {cs_n, ras_n, cas_n, we_n}
//                ba_o, a_o           - SDRAM bank / address lines
//                init_done_o         - init sequence complete
//  Revision    : 1.0 - initial release
// ============================================================================
module pkmc_cmdseq
    import pkmc_cmdseq_pkg::*;
#(
    parameter logic [15:0] INIT_CYCLES  = 16'd100,
    parameter int          T_RP         = 2,
    parameter int          T_RCD        = 2,
    parameter int          T_RFC        = 7,
    parameter int          T_WR         = 2,
    parameter int          CAS_LAT      = 2,
    parameter int          REF_INTERVAL = 780,
    parameter logic [11:0] MODE_REG     = 12'h022
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [1:0]             bank_i,
    input  logic [11:0]            row_i,
    input  logic [7:0]             col_i,
    output logic                   ack_o,
    output logic                   rd_valid_o,
    output logic [COMMAND_LEN-1:0] command_o,
    output logic [1:0]             ba_o,
    output logic [11:0]            a_o,
    output logic                   init_done_o
);

    localparam logic [3:0] c_ST_INIT_WAIT = 4'd0;
    localparam logic [3:0] c_ST_INIT_PRE  = 4'd1;
    localparam logic [3:0] c_ST_INIT_REF1 = 4'd2;
    localparam logic [3:0] c_ST_INIT_REF2 = 4'd3;
    localparam logic [3:0] c_ST_INIT_LMR  = 4'd4;
    localparam logic [3:0] c_ST_IDLE      = 4'd5;
    localparam logic [3:0] c_ST_REF       = 4'd6;
    localparam logic [3:0] c_ST_ACT       = 4'd7;
    localparam logic [3:0] c_ST_RW        = 4'd8;

    // wait_cnt load values: the issuing cycle itself counts as one cycle.
    localparam logic [15:0] c_WAIT_RP  = 16'(T_RP - 1);
    localparam logic [15:0] c_WAIT_RFC = 16'(T_RFC - 1);
    localparam logic [15:0] c_WAIT_RCD = 16'(T_RCD - 1);
    localparam logic [15:0] c_WAIT_WR  = 16'(T_WR + T_RP - 1);
    localparam logic [15:0] c_WAIT_RD  = 16'(CAS_LAT + T_RP - 1);
    // Remaining wait count in the cycle before the read-data pulse, which
    // lands CAS_LAT cycles after the RD cycle.
    localparam logic [15:0] c_RD_PULSE_AT = 16'(T_RP);

    logic [3:0]       r_state_q;
    logic [3:0]       w_state_d;
    logic [3:0]       w_idle_next;
    logic             w_issue;
    logic             w_timer_done;
    logic [15:0]      r_wait_q;
    logic [15:0]      w_wait_d;
    logic [COMMAND_LEN-1:0] r_command_q;
    logic [COMMAND_LEN-1:0] w_command_d;
    logic [11:0]      r_a_q;
    logic [11:0]      w_a_d;
    logic [1:0]       r_ba_q;
    logic [1:0]       w_ba_d;
    logic             r_ack_q;
    logic             w_ack_d;
    logic             r_rd_valid_q;
    logic             w_rd_valid_d;
    logic             r_init_done_q;
    logic             w_init_done_d;
    acc_t             r_acc_q;
    acc_t             w_acc_d;
    logic             w_ref_pending;
    logic             w_ack_refresh;

    pkmc_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_refresh_timer (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (r_init_done_q),
        .ack_refresh_i (w_ack_refresh),
        .ref_pending_o (w_ref_pending)
    );

    assign w_timer_done = (r_wait_q == 16'd0);

    // State register (holds the registered outputs alongside the state).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q     <= c_ST_INIT_WAIT;
            r_wait_q      <= INIT_CYCLES - 16'd1;
            r_command_q   <= c_CMD_NOP;
            r_a_q         <= 12'd0;
            r_ba_q        <= 2'd0;
            r_ack_q       <= 1'b0;
            r_rd_valid_q  <= 1'b0;
            r_init_done_q <= 1'b0;
            r_acc_q       <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_wait_q      <= w_wait_d;
            r_command_q   <= w_command_d;
            r_a_q         <= w_a_d;
            r_ba_q        <= w_ba_d;
            r_ack_q       <= w_ack_d;
            r_rd_valid_q  <= w_rd_valid_d;
            r_init_done_q <= w_init_done_d;
            r_acc_q       <= w_acc_d;
        end
    end

    // Next-state logic. w_issue marks a transition into a command-issuing
    // state; the command itself is registered on that same edge.
    always_comb begin
        w_idle_next = c_ST_IDLE;
        if (w_ref_pending) begin
            w_idle_next = c_ST_REF;
        end else if (req_i) begin
            w_idle_next = c_ST_ACT;
        end

        w_state_d = r_state_q;
        w_issue   = 1'b0;
        case (r_state_q)
            c_ST_INIT_WAIT: if (w_timer_done) begin
                w_state_d = c_ST_INIT_PRE;
                w_issue   = 1'b1;
            end
            c_ST_INIT_PRE: if (w_timer_done) begin
                w_state_d = c_ST_INIT_REF1;
                w_issue   = 1'b1;
            end
            c_ST_INIT_REF1: if (w_timer_done) begin
                w_state_d = c_ST_INIT_REF2;
                w_issue   = 1'b1;
            end
            c_ST_INIT_REF2: if (w_timer_done) begin
                w_state_d = c_ST_INIT_LMR;
                w_issue   = 1'b1;
            end
            c_ST_INIT_LMR: if (w_timer_done) begin
                w_state_d = c_ST_IDLE;
            end
            c_ST_IDLE: begin
                w_state_d = w_idle_next;
                w_issue   = (w_idle_next != c_ST_IDLE);
            end
            // After tRFC the next command may go out at once, so a request
            // held off by the refresh is served without an IDLE cycle.
            c_ST_REF: if (w_timer_done) begin
                w_state_d = w_idle_next;
                w_issue   = (w_idle_next != c_ST_IDLE);
            end
            c_ST_ACT: if (w_timer_done) begin
                w_state_d = c_ST_RW;
                w_issue   = 1'b1;
            end
            c_ST_RW: if (w_timer_done) begin
                w_state_d = c_ST_IDLE;
            end
            default: begin
                w_state_d = c_ST_INIT_WAIT;
            end
        endcase
    end

    // Output logic: next values of the registered outputs and wait_cnt.
    always_comb begin
        w_command_d   = c_CMD_NOP;
        w_a_d         = r_a_q;
        w_ba_d        = r_ba_q;
        w_wait_d      = w_timer_done ? 16'd0 : (r_wait_q - 16'd1);
        w_acc_d       = r_acc_q;
        w_rd_valid_d  = (r_state_q == c_ST_RW) && !r_acc_q.we &&
                        (r_wait_q == c_RD_PULSE_AT);
        w_ack_d       = w_rd_valid_d;
        w_init_done_d = r_init_done_q;
        w_ack_refresh = 1'b0;

        if (w_issue) begin
            case (w_state_d)
                c_ST_INIT_PRE: begin
                    w_command_d = c_CMD_PRE;
                    w_a_d       = 12'h400;     // A10: precharge all banks
                    w_wait_d    = c_WAIT_RP;
                end
                c_ST_INIT_REF1, c_ST_INIT_REF2: begin
                    w_command_d = c_CMD_REF;
                    w_wait_d    = c_WAIT_RFC;
                end
                c_ST_REF: begin
                    w_command_d   = c_CMD_REF;
                    w_wait_d      = c_WAIT_RFC;
                    w_ack_refresh = 1'b1;
                end
                c_ST_INIT_LMR: begin
                    w_command_d = c_CMD_LMR;
                    w_a_d       = MODE_REG;
                    w_ba_d      = 2'd0;
                    w_wait_d    = 16'd1;
                end
                c_ST_ACT: begin
                    w_command_d  = c_CMD_ACT;
                    w_ba_d       = bank_i;
                    w_a_d        = row_i;
                    w_acc_d.we   = we_i;
                    w_acc_d.bank = bank_i;
                    w_acc_d.col  = col_i;
                    w_wait_d     = c_WAIT_RCD;
                end
                c_ST_RW: begin
                    w_command_d = r_acc_q.we ? c_CMD_WR : c_CMD_RD;
                    w_a_d       = rw_addr(r_acc_q.col);
                    w_ba_d      = r_acc_q.bank;
                    w_ack_d     = r_acc_q.we;
                    w_wait_d    = r_acc_q.we ? c_WAIT_WR : c_WAIT_RD;
                end
                default: begin
                    w_command_d = c_CMD_NOP;
                end
            endcase
        end

        if ((r_state_q == c_ST_INIT_LMR) && (w_state_d == c_ST_IDLE)) begin
            w_init_done_d = 1'b1;
        end
    end

    assign command_o   = r_command_q;
    assign a_o         = r_a_q;
    assign ba_o        = r_ba_q;
    assign ack_o       = r_ack_q;
    assign rd_valid_o  = r_rd_valid_q;
    assign init_done_o = r_init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_pkmc_cmdseq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pkmc_cmdseq
//  Description : Self-checking bench for pkmc_cmdseq: init sequence, a table
//                of read/write accesses, idle refresh, refresh/request
//                collision, request dropped after ACT and mid-access reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pkmc_cmdseq;

    localparam logic [3:0] c_NOP = 4'b0111;
    localparam logic [3:0] c_PRE = 4'b0010;
    localparam logic [3:0] c_REF = 4'b0001;
    localparam logic [3:0] c_LMR = 4'b0000;
    localparam logic [3:0] c_ACT = 4'b0011;
    localparam logic [3:0] c_RD  = 4'b0101;
    localparam logic [3:0] c_WR  = 4'b0100;

    logic        clk_i  = 1'b0;
    logic        rst_i  = 1'b1;
    logic        req_i  = 1'b0;
    logic        we_i   = 1'b0;
    logic [1:0]  bank_i = 2'd0;
    logic [11:0] row_i  = 12'd0;
    logic [7:0]  col_i  = 8'd0;
    logic        ack_o;
    logic        rd_valid_o;
    logic [3:0]  command_o;
    logic [1:0]  ba_o;
    logic [11:0] a_o;
    logic        init_done_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_done = 0;

    pkmc_cmdseq dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .bank_i      (bank_i),
        .row_i       (row_i),
        .col_i       (col_i),
        .ack_o       (ack_o),
        .rd_valid_o  (rd_valid_o),
        .command_o   (command_o),
        .ba_o        (ba_o),
        .a_o         (a_o),
        .init_done_o (init_done_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [1:0]  bank;
        logic [11:0] row;
        logic [7:0]  col;
        logic [11:0] exp_act_a;
        logic [3:0]  exp_rw_cmd;
        logic [11:0] exp_rw_a;
        int          exp_ack_off;   // cycles after RD/WR where ack_o pulses
        logic        exp_rdv;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic nops(input int n);
        repeat (n) begin
            step();
            chk("nop", command_o, c_NOP);
        end
    endtask

    // Entered in the first cycle after the last reset edge.
    task automatic check_init();
        for (int i = 0; i < 100; i++) begin
            chk("init_wait_nop", command_o, c_NOP);
            chk("init_done_low", init_done_o, 1'b0);
            step();
        end
        chk("init_pre", command_o, c_PRE);
        chk("init_pre_a10", a_o[10], 1'b1);
        nops(1);
        step();
        chk("init_ref1", command_o, c_REF);
        nops(6);
        step();
        chk("init_ref2", command_o, c_REF);
        nops(6);
        step();
        chk("init_lmr", command_o, c_LMR);
        chk("lmr_a", a_o, 12'h022);
        chk("lmr_ba", ba_o, 2'd0);
        step();
        chk("lmr_gap_nop", command_o, c_NOP);
        chk("init_done_early", init_done_o, 1'b0);
        step();
        chk("idle_nop", command_o, c_NOP);
        chk("init_done", init_done_o, 1'b1);
        t_done = cyc;
    endtask

    // Starts in an IDLE cycle; ends in the IDLE cycle after the access.
    task automatic do_vec(input vec_t v, output int act_c);
        int n_ack;
        int n_rdv;
        we_i = v.we; bank_i = v.bank; row_i = v.row; col_i = v.col;
        req_i = 1'b1;
        step();
        chk("act_cmd", command_o, c_ACT);
        chk("act_ba", ba_o, v.bank);
        chk("act_a", a_o, v.exp_act_a);
        act_c = cyc;
        // Inputs must be ignored once ACT is out.
        we_i = ~v.we; bank_i = ~v.bank; row_i = ~v.row; col_i = ~v.col;
        step();
        chk("rcd_nop", command_o, c_NOP);
        step();
        chk("rw_cmd", command_o, v.exp_rw_cmd);
        chk("rw_a", a_o, v.exp_rw_a);
        chk("rw_ba", ba_o, v.bank);
        n_ack = 0;
        n_rdv = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) chk("rw_tail_nop", command_o, c_NOP);
            chk("ack", ack_o, (k == v.exp_ack_off) ? 1'b1 : 1'b0);
            chk("rd_valid", rd_valid_o, (v.exp_rdv && k == v.exp_ack_off) ? 1'b1 : 1'b0);
            n_ack += int'(ack_o);
            n_rdv += int'(rd_valid_o);
            if (ack_o) req_i = 1'b0;
            step();
        end
        chk("ack_count", n_ack, 1);
        chk("rdv_count", n_rdv, v.exp_rdv ? 1 : 0);
        chk("back_idle_nop", command_o, c_NOP);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_act;
        int act_c;
        int r_cyc;

        vecs[0] = '{1'b1, 2'd1, 12'h0A5, 8'h3C, 12'h0A5, c_WR, 12'h43C, 0, 1'b0};
        vecs[1] = '{1'b0, 2'd2, 12'hFFF, 8'hFF, 12'hFFF, c_RD, 12'h4FF, 2, 1'b1};
        vecs[2] = '{1'b1, 2'd3, 12'h000, 8'h00, 12'h000, c_WR, 12'h400, 0, 1'b0};
        vecs[3] = '{1'b0, 2'd0, 12'h800, 8'h80, 12'h800, c_RD, 12'h480, 2, 1'b1};

        rst_i = 1'b1;
        repeat (3) step();
        chk("rst_cmd", command_o, c_NOP);
        chk("rst_a", a_o, 12'd0);
        chk("rst_ba", ba_o, 2'd0);
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_rdv", rd_valid_o, 1'b0);
        chk("rst_init_done", init_done_o, 1'b0);
        rst_i = 1'b0;

        // Request raised during init must be held off until IDLE.
        we_i = vecs[0].we; bank_i = vecs[0].bank; row_i = vecs[0].row; col_i = vecs[0].col;
        req_i = 1'b1;
        check_init();

        prev_act = 0;
        for (int i = 0; i < 4; i++) begin
            do_vec(vecs[i], act_c);
            if (i == 0) chk("first_act_latency", act_c - t_done, 1);
            else        chk("act_gap", act_c - prev_act, 7);
            prev_act = act_c;
        end

        // Idle refresh: pending visible at t_done+780, REF one cycle later.
        while (cyc < t_done + 780) begin
            chk("pre_ref_nop", command_o, c_NOP);
            step();
        end
        chk("pre_ref_nop", command_o, c_NOP);
        step();
        chk("idle_ref", command_o, c_REF);
        chk("idle_ref_cycle", cyc - t_done, 781);
        nops(7);

        // Refresh and request in the same IDLE cycle: REF first.
        while (cyc < t_done + 1560) begin
            chk("pre_ref2_nop", command_o, c_NOP);
            step();
        end
        we_i = 1'b0; bank_i = 2'd2; row_i = 12'h123; col_i = 8'h45;
        req_i = 1'b1;
        step();
        chk("coll_ref", command_o, c_REF);
        r_cyc = cyc;
        nops(6);
        step();
        chk("coll_act", command_o, c_ACT);
        chk("coll_act_gap", cyc - r_cyc, 7);
        chk("coll_act_a", a_o, 12'h123);
        chk("coll_act_ba", ba_o, 2'd2);
        nops(1);
        step();
        chk("coll_rd", command_o, c_RD);
        chk("coll_rd_a", a_o, 12'h445);
        step();
        chk("coll_no_early_ack", ack_o, 1'b0);
        step();
        chk("coll_ack", ack_o, 1'b1);
        chk("coll_rdv", rd_valid_o, 1'b1);
        req_i = 1'b0;
        step();
        chk("coll_ack_once", ack_o, 1'b0);
        step();
        chk("coll_idle_nop", command_o, c_NOP);

        // Request dropped right after ACT: access still completes.
        we_i = 1'b1; bank_i = 2'd1; row_i = 12'h5A5; col_i = 8'h11;
        req_i = 1'b1;
        step();
        chk("drop_act", command_o, c_ACT);
        req_i = 1'b0;
        step();
        step();
        chk("drop_wr", command_o, c_WR);
        chk("drop_wr_a", a_o, 12'h411);
        chk("drop_ack", ack_o, 1'b1);
        nops(3);
        step();
        chk("drop_idle_nop", command_o, c_NOP);

        // Reset during the tRCD wait aborts the access and re-runs init.
        we_i = 1'b0; bank_i = 2'd3; row_i = 12'h0F0; col_i = 8'h22;
        req_i = 1'b1;
        step();
        chk("rst_act", command_o, c_ACT);
        step();
        rst_i = 1'b1;
        step();
        chk("midrst_cmd", command_o, c_NOP);
        chk("midrst_init_done", init_done_o, 1'b0);
        chk("midrst_ack", ack_o, 1'b0);
        req_i = 1'b0;
        rst_i = 1'b0;
        check_init();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
